// File: rtl/mfda_ctrl_pkg.sv
// rtl/mfda_ctrl_pkg.sv - shared types and helpers for the inlet dispense sequencer
// Purpose: sequencer state encoding, default counter width and the
//          next-nonzero-inlet search used when choosing the next valve.
// Ports:   none (package).
package mfda_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    SETTLE,
    FINISH
  } seq_state_t;

  localparam int DEF_CNT_W  = 16;
  // Upper bound on inlets the search helper can scan; callers zero-pad.
  localparam int MAX_INLETS = 8;

  // Lowest index >= from whose bit is set in nz_mask; MAX_INLETS if none.
  function automatic int next_inlet(input logic [MAX_INLETS-1:0] nz_mask,
                                    input int from);
    next_inlet = MAX_INLETS;
    for (int i = MAX_INLETS - 1; i >= 0; i--) begin
      if (i >= from && nz_mask[i]) next_inlet = i;
    end
  endfunction

endpackage

// File: rtl/inlet_dispense_sequencer_if.sv
// rtl/inlet_dispense_sequencer_if.sv - host/valve signal bundle for the dispense sequencer
// Purpose: groups the command inputs and valve/status outputs.
// Ports:   master = host side (drives start/dur/abort),
//          slave  = sequencer side (drives valve_en/pump_en/busy/active_inlet/done/aborted).
interface inlet_dispense_sequencer_if #(
  parameter int NUM_INLETS = 3,
  parameter int CNT_W      = 16
);
  localparam int IDX_W = (NUM_INLETS > 1) ? $clog2(NUM_INLETS) : 1;

  logic                        start;
  logic [NUM_INLETS*CNT_W-1:0] dur;
  logic                        abort;
  logic [NUM_INLETS-1:0]       valve_en;
  logic                        pump_en;
  logic                        busy;
  logic [IDX_W-1:0]            active_inlet;
  logic                        done;
  logic                        aborted;

  modport master (
    output start, dur, abort,
    input  valve_en, pump_en, busy, active_inlet, done, aborted
  );

  modport slave (
    input  start, dur, abort,
    output valve_en, pump_en, busy, active_inlet, done, aborted
  );

endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter timing dispense and settle phases
// Purpose: counts down from a loaded value and flags the last cycle of a phase.
// Ports:   clk, rst (sync, active-high), load_i/load_val_i (reload),
//          expire_o (high while the count is 1, i.e. the final phase cycle).
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // Stops at zero instead of wrapping; a load of zero parks the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/inlet_dispense_sequencer.sv
// rtl/inlet_dispense_sequencer.sv - timed one-at-a-time inlet valve and pump sequencer
// Purpose: on start, opens each inlet with a nonzero duration in index order,
//          separated by an all-closed settle gap, then pulses done.
// Ports:   clk, rst (sync, active-high), bus (slave modport: start/dur/abort in;
//          valve_en/pump_en/busy/active_inlet/done/aborted out, all registered).
module inlet_dispense_sequencer
  import mfda_ctrl_pkg::*;
#(
  parameter int NUM_INLETS    = 3,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  inlet_dispense_sequencer_if.slave   bus
);

  localparam int IDX_W = (NUM_INLETS > 1) ? $clog2(NUM_INLETS) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  seq_state_t                  state_q;
  logic [NUM_INLETS*CNT_W-1:0] dur_q;
  logic [NUM_INLETS-1:0]       valve_q;
  logic                        pump_q;
  logic                        busy_q;
  logic [IDX_W-1:0]            active_q;
  logic                        done_q;
  logic                        aborted_q;

  logic [MAX_INLETS-1:0]       nz_in;
  logic [MAX_INLETS-1:0]       nz_q;
  int                          first_ix;
  int                          next_ix;
  logic                        first_ok;
  logic                        next_ok;
  logic [IDX_W-1:0]            first_sel;
  logic [IDX_W-1:0]            next_sel;

  logic                        tmr_load;
  logic [CNT_W-1:0]            tmr_val;
  logic                        tmr_expire;
  logic                        abort_hit;

  function automatic logic [CNT_W-1:0] pick(input logic [NUM_INLETS*CNT_W-1:0] v,
                                            input logic [IDX_W-1:0] ix);
    pick = v[ix*CNT_W +: CNT_W];
  endfunction

  function automatic logic [NUM_INLETS-1:0] onehot(input logic [IDX_W-1:0] ix);
    onehot = NUM_INLETS'(1) << ix;
  endfunction

  // Nonzero maps: live input for the accept decision, latched copy afterwards.
  always_comb begin
    nz_in = '0;
    nz_q  = '0;
    for (int i = 0; i < NUM_INLETS; i++) begin
      nz_in[i] = |bus.dur[i*CNT_W +: CNT_W];
      nz_q[i]  = |dur_q[i*CNT_W +: CNT_W];
    end
  end

  assign first_ix  = next_inlet(nz_in, 0);
  assign next_ix   = next_inlet(nz_q, int'(active_q) + 1);
  assign first_ok  = (first_ix < NUM_INLETS);
  assign next_ok   = (next_ix < NUM_INLETS);
  assign first_sel = first_ok ? IDX_W'(first_ix) : '0;
  assign next_sel  = next_ok ? IDX_W'(next_ix) : '0;
  assign abort_hit = (state_q != IDLE) && bus.abort;

  // Timer reload is decided on the same edge as the state change, so each
  // phase's first cycle already sees its full count.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (abort_hit) begin
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && first_ok) begin
            tmr_load = 1'b1;
            tmr_val  = pick(bus.dur, first_sel);
          end
        end
        DISPENSE: begin
          if (tmr_expire) begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (tmr_expire) begin
            tmr_load = 1'b1;
            tmr_val  = next_ok ? pick(dur_q, next_sel) : '0;
          end
        end
        FINISH:  tmr_load = 1'b1;
        default: tmr_load = 1'b1;
      endcase
    end
  end

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_expire)
  );

  // Every valve transition passes through SETTLE (all closed), so valve_q
  // never steps from one open inlet straight to another.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      valve_q   <= '0;
      pump_q    <= 1'b0;
      busy_q    <= 1'b0;
      active_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_hit) begin
        state_q   <= IDLE;
        valve_q   <= '0;
        pump_q    <= 1'b0;
        busy_q    <= 1'b0;
        active_q  <= '0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              dur_q  <= bus.dur;
              busy_q <= 1'b1;
              if (first_ok) begin
                state_q  <= DISPENSE;
                valve_q  <= onehot(first_sel);
                pump_q   <= 1'b1;
                active_q <= first_sel;
              end else begin
                state_q  <= FINISH;
                active_q <= '0;
              end
            end
          end
          DISPENSE: begin
            if (tmr_expire) begin
              state_q <= SETTLE;
              valve_q <= '0;
              pump_q  <= 1'b0;
            end
          end
          SETTLE: begin
            if (tmr_expire) begin
              if (next_ok) begin
                state_q  <= DISPENSE;
                valve_q  <= onehot(next_sel);
                pump_q   <= 1'b1;
                active_q <= next_sel;
              end else begin
                state_q <= FINISH;
              end
            end
          end
          FINISH: begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            active_q <= '0;
            done_q   <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.valve_en     = valve_q;
  assign bus.pump_en      = pump_q;
  assign bus.busy         = busy_q;
  assign bus.active_inlet = active_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;

endmodule

// File: tb/tb_inlet_dispense_sequencer.sv
// tb/tb_inlet_dispense_sequencer.sv - self-checking bench for inlet_dispense_sequencer
module tb_inlet_dispense_sequencer;

  localparam int N      = 3;
  localparam int CW     = 16;
  localparam int SETTLE = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inlet_dispense_sequencer_if #(.NUM_INLETS(N), .CNT_W(CW)) bus_if ();

  inlet_dispense_sequencer #(
    .NUM_INLETS(N), .CNT_W(CW), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  typedef struct {
    logic [2:0] v;
    logic       b;
    logic [1:0] a;
    logic       d;
    logic       ab;
  } exp_t;

  exp_t tr[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(logic [2:0] v, logic b, logic [1:0] a, logic d, logic ab);
    exp_t e;
    e.v = v; e.b = b; e.a = a; e.d = d; e.ab = ab;
    return e;
  endfunction

  function automatic logic [8:0] obs_vec();
    return {bus_if.valve_en, bus_if.pump_en, bus_if.busy, bus_if.active_inlet,
            bus_if.done, bus_if.aborted};
  endfunction

  function automatic logic [8:0] exp_vec(exp_t e);
    return {e.v, |e.v, e.b, e.a, e.d, e.ab};
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic cycle_chk(string tag, exp_t e);
    check(tag, 32'(obs_vec()), 32'(exp_vec(e)));
    check({tag, "_inv"},
          {31'b0, (bus_if.pump_en === |bus_if.valve_en) && $onehot0(bus_if.valve_en)},
          32'd1);
  endtask

  // Expected per-cycle outputs from the cycle after accept through the done cycle.
  task automatic build(int da, int db, int dc);
    int d[3];
    int last;
    d[0] = da; d[1] = db; d[2] = dc;
    last = 0;
    tr.delete();
    for (int i = 0; i < 3; i++) begin
      if (d[i] > 0) begin
        last = i;
        repeat (d[i]) tr.push_back(mk(3'(1 << i), 1'b1, 2'(i), 1'b0, 1'b0));
        repeat (SETTLE) tr.push_back(mk(3'b000, 1'b1, 2'(i), 1'b0, 1'b0));
      end
    end
    tr.push_back(mk(3'b000, 1'b1, 2'(last), 1'b0, 1'b0));
    tr.push_back(mk(3'b000, 1'b0, 2'd0, 1'b1, 1'b0));
  endtask

  task automatic play(int lo, int hi, string tag);
    for (int j = lo; j <= hi; j++) begin
      cycle_chk($sformatf("%s[%0d]", tag, j), tr[j]);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first post-accept cycle.
  task automatic launch(int da, int db, int dc, bit hold);
    bus_if.dur   = {CW'(dc), CW'(db), CW'(da)};
    bus_if.start = 1'b1;
    build(da, db, dc);
    @(negedge clk);
    if (!hold) begin
      bus_if.start = 1'b0;
      bus_if.dur   = 48'({$urandom(), $urandom()});
    end
  endtask

  exp_t idle_e;
  exp_t abort_e;

  initial begin
    int n;
    int j;
    int da, db, dc;
    idle_e  = mk(3'b000, 1'b0, 2'd0, 1'b0, 1'b0);
    abort_e = mk(3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.dur   = '0;
    repeat (3) @(negedge clk);
    cycle_chk("reset", idle_e);
    rst = 1'b0;
    @(negedge clk);
    cycle_chk("idle0", idle_e);

    // Basic three-inlet sequence
    launch(2, 3, 4, 0);
    play(0, tr.size() - 1, "t1");
    cycle_chk("t1_idle", idle_e);

    // Middle inlet skipped
    launch(2, 0, 5, 0);
    play(0, tr.size() - 1, "t2");
    cycle_chk("t2_idle", idle_e);

    // All-zero durations go straight to FINISH
    launch(0, 0, 0, 0);
    play(0, tr.size() - 1, "t3");
    cycle_chk("t3_idle", idle_e);

    // Abort in the 2nd cycle of inlet1 dispense, then a full normal run
    launch(2, 3, 4, 0);
    play(0, 10, "t4");
    cycle_chk("t4[11]", tr[11]);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    cycle_chk("t4_aborted", abort_e);
    @(negedge clk);
    cycle_chk("t4_idle", idle_e);
    launch(2, 3, 4, 0);
    play(0, tr.size() - 1, "t4b");
    cycle_chk("t4b_idle", idle_e);

    // Start held high: back-to-back sequences, starts during busy ignored
    launch(1, 1, 1, 1);
    n = tr.size();
    play(0, n - 1, "t5a");
    play(0, n - 2, "t5b");
    bus_if.start = 1'b0;
    play(n - 1, n - 1, "t5b");
    cycle_chk("t5_idle", idle_e);

    // Abort alone in IDLE does nothing; abort with start in IDLE lets start win
    bus_if.abort = 1'b1;
    @(negedge clk);
    cycle_chk("idle_abort", idle_e);
    launch(1, 2, 0, 0);
    bus_if.abort = 1'b0;
    play(0, tr.size() - 1, "t7");
    cycle_chk("t7_idle", idle_e);

    // Abort during FINISH suppresses done
    launch(0, 0, 0, 0);
    cycle_chk("t8_fin", tr[0]);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    cycle_chk("t8_aborted", abort_e);
    @(negedge clk);
    cycle_chk("t8_idle", idle_e);

    // Reset mid-SETTLE
    launch(3, 2, 4, 0);
    play(0, 5, "t6s");
    cycle_chk("t6s[6]", tr[6]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycle_chk("t6s_rst", idle_e);
    @(negedge clk);
    cycle_chk("t6s_idle", idle_e);

    // Reset mid-DISPENSE of inlet2
    launch(3, 2, 4, 0);
    play(0, 21, "t6d");
    cycle_chk("t6d[22]", tr[22]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycle_chk("t6d_rst", idle_e);
    @(negedge clk);
    cycle_chk("t6d_idle", idle_e);

    // Duration wider than 8 bits
    launch(300, 0, 1, 0);
    play(0, tr.size() - 1, "tlong");
    cycle_chk("tlong_idle", idle_e);

    // Randomized sequences with optional abort at a random busy cycle
    for (int r = 0; r < 10; r++) begin
      da = int'($urandom_range(0, 5));
      db = int'($urandom_range(0, 5));
      dc = int'($urandom_range(0, 5));
      launch(da, db, dc, 0);
      n = tr.size();
      if ($urandom_range(0, 1) == 1) begin
        j = int'($urandom_range(0, n - 2));
        play(0, j - 1, $sformatf("r%0d", r));
        cycle_chk($sformatf("r%0d[%0d]", r, j), tr[j]);
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
        cycle_chk($sformatf("r%0d_aborted", r), abort_e);
        @(negedge clk);
      end else begin
        play(0, n - 1, $sformatf("r%0d", r));
      end
      cycle_chk($sformatf("r%0d_idle", r), idle_e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
